// File: rtl/cpuDefine_pkg.sv
// Shared CPU definitions: instruction word type, canonical NOP and the
// fetch-queue entry record {pc, instr, adef} passed from fetch to decode.
// No ports; imported by the fetch queue and its neighbours.
package cpuDefine;

    typedef logic [31:0] Instr;

    // andi r0,r0,0 -- presented to decode whenever nothing valid is queued
    localparam Instr NOP = 32'h0340_0000;

    typedef struct packed {
        logic [31:0] pc;
        Instr        instr;
        logic        adef;
    } FetchEntry;

endpackage

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of FetchEntry.
// Latency: one cycle push-to-out (no bypass); flush empties on the next edge.
// Backpressure: in_ready = (count < DEPTH) from registered state only; out_ready pops head.
// Ports: clk/rst (async active-high), in_* push side, out_* head entry, flush, count.
module inst_fetch_queue
    import cpuDefine::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     in_adef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_adef,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Storage is deliberately not reset; pointers and count define validity.
    FetchEntry mem [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;
    FetchEntry in_ent;
    FetchEntry head_ent;

    assign in_ready  = (count_q < CNT_FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // Flush wins over both handshakes in the same cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign in_ent = '{pc: in_pc, instr: in_instr, adef: in_adef};
    assign head_ent = mem[head_q];

    // Empty queue shows a harmless NOP so decode never sees stale storage.
    always_comb begin
        out_pc    = 32'h0;
        out_instr = NOP;
        out_adef  = 1'b0;
        if (out_valid) begin
            out_pc    = head_ent.pc;
            out_instr = head_ent.instr;
            out_adef  = head_ent.adef;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Power-of-two depth: pointer overflow is the modulo wrap.
            if (push) tail_d = tail_q + PTR_ONE;
            if (pop)  head_d = head_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= in_ent;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_adef;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adef;
    logic        flush;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_adef   (in_adef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_adef  (out_adef),
        .flush     (flush),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ad, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        in_adef   = ad;
        out_ready = rdy;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_instr", out_instr,      32'h0340_0000);
        check("rst_out_pc",    out_pc,         32'h0);
        check("rst_out_adef",  32'(out_adef),  32'd0);
        tick();
        tick();
        rst = 1'b0;

        // First push straight after reset; no bypass to the output.
        drive(1'b1, 32'h1c00_0000, 32'h0280_0c21, 1'b0, 1'b0);
        #1;
        check("nobypass_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("push1_out_valid", 32'(out_valid), 32'd1);
        check("push1_out_pc",    out_pc,         32'h1c00_0000);
        check("push1_out_instr", out_instr,      32'h0280_0c21);
        check("push1_count",     32'(count),     32'd1);
        out_ready = 1'b1;
        tick();
        check("pop1_count", 32'(count), 32'd0);
        check("pop1_empty_instr", out_instr, 32'h0340_0000);

        // Fill to capacity with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_hold_pc",  out_pc,        32'h100);
        // Fifth word presented while full must be refused.
        drive(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        check("full_refuse_count", 32'(count), 32'd4);
        check("full_hold_instr",   out_instr,  32'hA0);
        // Full with push and pop offered together: pop only.
        out_ready = 1'b1;
        tick();
        check("fullpp_count",    32'(count),    32'd3);
        check("fullpp_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("order_pc",    out_pc,    32'h100 + 32'(i * 4));
            check("order_instr", out_instr, 32'hA0 + 32'(i));
            tick();
        end
        check("drain_count", 32'(count), 32'd0);

        // Flush with simultaneous push and pop at count 2.
        drive(1'b1, 32'h200, 32'hB0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h204, 32'hB1, 1'b0, 1'b0);
        tick();
        check("preflush_count", 32'(count), 32'd2);
        drive(1'b1, 32'h208, 32'hB2, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_count",     32'(count),     32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_instr", out_instr,      32'h0340_0000);
        check("flush_in_ready",  32'(in_ready),  32'd1);

        // Ten entries streamed with overlapping push/pop across pointer wrap.
        drive(1'b1, 32'h2000, 32'h1000, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            if (k < 10) drive(1'b1, 32'h2000 + 32'(k * 4), 32'h1000 + 32'(k), (k == 7), 1'b1);
            else        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            check("wrap_pc",    out_pc,         32'h2000 + 32'((k - 1) * 4));
            check("wrap_instr", out_instr,      32'h1000 + 32'(k - 1));
            check("wrap_adef",  32'(out_adef),  32'((k - 1) == 7));
            tick();
            if (k < 10) check("wrap_count", 32'(count), 32'd1);
        end
        check("wrap_end_count", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        check("prerst_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_count",     32'(count),     32'd0);
        check("arst_out_instr", out_instr,      32'h0340_0000);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h400, 32'hD0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        check("postrst_count", 32'(count),    32'd1);
        check("postrst_pc",    out_pc,        32'h400);
        check("postrst_adef",  32'(out_adef), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  fetch stage presents an instruction.
REQ-005 SHALL have port in_ready  output  1  queue accepts an instruction this cycle.
REQ-006 SHALL have port in_pc  input  32  PC of fetched instruction.
REQ-007 SHALL have port in_instr  input  32  fetched instruction word.
REQ-008 SHALL have port in_adef  input  1  fetch address-error flag travelling with the entry.
REQ-009 SHALL have port out_valid  output  1  head entry is presented to decode.
REQ-010 SHALL have port out_ready  input  1  decode consumes the head entry this cycle.
REQ-011 SHALL have port out_pc  output  32  head entry PC.
REQ-012 SHALL have port out_instr  output  32  head entry instruction word (to the decoder's instr input).
REQ-013 SHALL have port out_adef  output  1  head entry address-error flag.
REQ-014 SHALL have port flush  input  1  redirect (branch taken, exception, ertn): discard all entries.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL store entries {pc, instr, adef} in a circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-017 SHALL push when in_valid && in_ready && !flush; tail advances by 1.
REQ-018 SHALL pop when out_valid && out_ready && !flush; head advances by 1.
REQ-019 SHALL drive in_ready = (count < DEPTH), from registered state only; no dependence on out_ready (full queue with simultaneous pop still refuses push).
REQ-020 SHALL drive out_valid = (count != 0); no bypass: a pushed entry first appears on out_* one cycle after the push edge.
REQ-021 SHALL, when count == 0, drive out_instr = NOP (0x03400000, andi r0,r0,0), out_pc = 0, out_adef = 0.
REQ-022 SHALL update count as +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
REQ-023 SHALL, on flush, set head = tail = count = 0 at the next edge; a same-cycle push or pop is discarded and flush has priority.
REQ-024 SHALL hold out_* stable while out_valid && !out_ready && !flush.
REQ-025 SHALL ignore in_pc/in_instr/in_adef when no push occurs; storage contents are not reset, only pointers and count.
REQ-026 SHALL preserve FIFO order; no entry is duplicated or dropped except by flush.

Reset
REQ-027 SHALL, while rst is high, asynchronously force head = tail = count = 0, giving out_valid = 0, in_ready = 1, out_instr = NOP, out_pc = 0, out_adef = 0.
REQ-028 SHALL treat reset asserted mid-operation as a flush; the first push after rst deasserts is accepted on the first rising edge.

Structure
REQ-029 SHALL take the NOP constant and a FetchEntry struct {pc[31:0], instr (Instr type), adef} from the shared cpuDefine package.
REQ-030 SHALL be a single module without sub-modules; storage is an unpacked array of FetchEntry.

Verification
REQ-031 Reset then push pc=0x1c000000 instr=0x02800c21 -> cycle+1 out_valid=1, out_pc=0x1c000000, out_instr=0x02800c21, count=1.
REQ-032 Push 4 entries with out_ready=0 -> count=4, in_ready=0; 5th presented word not stored; pops return the 4 entries in push order.
REQ-033 Full queue, in_valid=1 and out_ready=1 in the same cycle -> pop only, count=3, next cycle in_ready=1.
REQ-034 count=2 with flush=1, in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, out_instr=0x03400000.
REQ-035 Push 10 entries with alternating push/pop across pointer wrap -> output sequence equals input sequence, in_adef=1 on entry 7 reappears only on entry 7.
REQ-036 rst pulse asserted mid-cycle with count=3 -> out_valid falls without a clock edge; count=0.
